sqrt_fp_round_pack: RTL and testbench

Output stage for the LAMP square-root / inverse-square-root datapath. It takes the unpacked, unrounded result from the sqrt core wrapper (sign, signed unbiased exponent, mantissa with hidden one plus 4 extra low bits) together with the operand special-case flags. It rounds to F_DW bits, re-biases, detects overflow and underflow, resolves special cases, and packs an IEEE-754 word. It is a 2-stage elastic pipeline with a valid/ready handshake on both sides.

---
 rtl/sqrt_fp_round_pack.sv | 211 +++++++++++++++++++++
 tb/tb_sqrt_fp_round_pack.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_fp_round_pack.sv
// Output stage of the LAMP sqrt / inverse-sqrt datapath: rounds, re-biases, resolves
// special operands and packs an IEEE-754 word behind a 2-stage valid/ready pipeline.
module sqrt_fp_round_pack #(
    parameter int unsigned E_DW = 8,
    parameter int unsigned F_DW = 23,
    parameter int unsigned BIAS = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   op_inv_i,
    input  logic [1:0]             rnd_mode_i,
    input  logic                   s_i,
    input  logic [E_DW:0]          e_i,
    input  logic [F_DW+4:0]        f_i,
    input  logic                   isZ_i,
    input  logic                   isInf_i,
    input  logic                   isSNAN_i,
    input  logic                   isQNAN_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [E_DW+F_DW:0]     result_o,
    output logic                   isInvalid_o,
    output logic                   isOverflow_o,
    output logic                   isUnderflow_o,
    output logic                   isInexact_o,
    output logic                   isDivZero_o
);

    localparam int unsigned W = 1 + E_DW + F_DW;

    localparam logic [1:0] RndRne = 2'b00;
    localparam logic [1:0] RndRtz = 2'b01;
    localparam logic [1:0] RndRup = 2'b10;
    localparam logic [1:0] RndRdn = 2'b11;

    localparam logic [W-1:0] QNAN   = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};
    localparam logic [W-1:0] P_INF  = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};
    localparam logic [W-1:0] MAX_FN = {1'b0, {(E_DW-1){1'b1}}, 1'b0, {F_DW{1'b1}}};

    localparam logic [E_DW+1:0] BIAS_W = (E_DW+2)'(BIAS);
    localparam logic [E_DW+1:0] MAX_EB = (E_DW+2)'((1 << E_DW) - 1);

    // ---------------------------------------------------------------- handshake
    logic s1_valid_q;
    logic s2_valid_q;
    logic s2_ready;
    logic accept;

    assign s2_ready = !s2_valid_q || ready_i;
    assign ready_o  = !s1_valid_q || s2_ready;
    assign accept   = valid_i && ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (ready_o) s1_valid_q <= valid_i;
            if (s2_ready) s2_valid_q <= s1_valid_q;
        end
    end

    // ---------------------------------------------------------------- stage 1
    logic lsb_bit;
    logic guard_bit;
    logic sticky_bit;
    logic inexact_d;
    logic inc_d;

    always_comb begin
        lsb_bit    = f_i[4];
        guard_bit  = f_i[3];
        sticky_bit = |f_i[2:0];
        inexact_d  = guard_bit | sticky_bit;
        inc_d      = 1'b0;
        unique case (rnd_mode_i)
            RndRne:  inc_d = guard_bit & (sticky_bit | lsb_bit);
            RndRtz:  inc_d = 1'b0;
            RndRup:  inc_d = !s_i & inexact_d;
            RndRdn:  inc_d = s_i & inexact_d;
            default: inc_d = 1'b0;
        endcase
    end

    logic            s1_sign_q;
    logic [E_DW:0]   s1_e_q;
    logic [F_DW:0]   s1_m_q;
    logic            s1_inc_q;
    logic            s1_inexact_q;
    logic            s1_inv_q;
    logic [1:0]      s1_rnd_q;
    logic            s1_z_q;
    logic            s1_inf_q;
    logic            s1_snan_q;
    logic            s1_qnan_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_sign_q    <= s_i;
            s1_e_q       <= e_i;
            s1_m_q       <= f_i[F_DW+4:4];
            s1_inc_q     <= inc_d;
            s1_inexact_q <= inexact_d;
            s1_inv_q     <= op_inv_i;
            s1_rnd_q     <= rnd_mode_i;
            s1_z_q       <= isZ_i;
            s1_inf_q     <= isInf_i;
            s1_snan_q    <= isSNAN_i;
            s1_qnan_q    <= isQNAN_i;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [F_DW+1:0] m_sum;
    logic            carry;
    logic [F_DW-1:0] frac;
    logic [E_DW+1:0] eb;
    logic            ovf;
    logic            unf;

    logic [W-1:0]    res_d;
    logic            inv_d;
    logic            ovf_d;
    logic            unf_d;
    logic            inx_d;
    logic            dz_d;

    always_comb begin
        m_sum = {1'b0, s1_m_q} + {{(F_DW+1){1'b0}}, s1_inc_q};
        carry = m_sum[F_DW+1];
        // On carry the mantissa is 10.00..0, so the shifted fraction is all zeros.
        frac  = carry ? m_sum[F_DW:1] : m_sum[F_DW-1:0];
        eb    = {s1_e_q[E_DW], s1_e_q} + BIAS_W + {{(E_DW+1){1'b0}}, carry};
        ovf   = !eb[E_DW+1] && (eb >= MAX_EB);
        unf   = eb[E_DW+1] || (eb == '0);

        res_d = {1'b0, eb[E_DW-1:0], frac};
        inv_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = s1_inexact_q;
        dz_d  = 1'b0;

        if (s1_snan_q) begin
            res_d = QNAN;
            inv_d = 1'b1;
            inx_d = 1'b0;
        end else if (s1_qnan_q) begin
            res_d = QNAN;
            inx_d = 1'b0;
        end else if (s1_z_q) begin
            inx_d = 1'b0;
            if (s1_inv_q) begin
                res_d = {s1_sign_q, P_INF[W-2:0]};
                dz_d  = 1'b1;
            end else begin
                res_d = {s1_sign_q, {(W-1){1'b0}}};
            end
        end else if (s1_inf_q) begin
            inx_d = 1'b0;
            if (s1_sign_q) begin
                res_d = QNAN;
                inv_d = 1'b1;
            end else begin
                res_d = s1_inv_q ? '0 : P_INF;
            end
        end else if (s1_sign_q) begin
            res_d = QNAN;
            inv_d = 1'b1;
            inx_d = 1'b0;
        end else if (ovf) begin
            res_d = (s1_rnd_q == RndRne || s1_rnd_q == RndRup) ? P_INF : MAX_FN;
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (unf) begin
            res_d = '0;
            unf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    logic [W-1:0] res_q;
    logic         inv_q;
    logic         ovf_q;
    logic         unf_q;
    logic         inx_q;
    logic         dz_q;

    always_ff @(posedge clk) begin
        if (s2_ready && s1_valid_q) begin
            res_q <= res_d;
            inv_q <= inv_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            inx_q <= inx_d;
            dz_q  <= dz_d;
        end
    end

    // Data registers are unreset, so outputs are masked while no beat is held.
    assign valid_o       = s2_valid_q;
    assign result_o      = s2_valid_q ? res_q : '0;
    assign isInvalid_o   = s2_valid_q & inv_q;
    assign isOverflow_o  = s2_valid_q & ovf_q;
    assign isUnderflow_o = s2_valid_q & unf_q;
    assign isInexact_o   = s2_valid_q & inx_q;
    assign isDivZero_o   = s2_valid_q & dz_q;

endmodule

// File: tb/tb_sqrt_fp_round_pack.sv
// Directed bench for sqrt_fp_round_pack: vector table, backpressure stream and
// mid-flight reset.
module tb_sqrt_fp_round_pack;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic        op_inv_i;
    logic [1:0]  rnd_mode_i;
    logic        s_i;
    logic [8:0]  e_i;
    logic [27:0] f_i;
    logic        isZ_i;
    logic        isInf_i;
    logic        isSNAN_i;
    logic        isQNAN_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        isInvalid_o;
    logic        isOverflow_o;
    logic        isUnderflow_o;
    logic        isInexact_o;
    logic        isDivZero_o;

    sqrt_fp_round_pack #(
        .E_DW(8),
        .F_DW(23),
        .BIAS(127)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .op_inv_i     (op_inv_i),
        .rnd_mode_i   (rnd_mode_i),
        .s_i          (s_i),
        .e_i          (e_i),
        .f_i          (f_i),
        .isZ_i        (isZ_i),
        .isInf_i      (isInf_i),
        .isSNAN_i     (isSNAN_i),
        .isQNAN_i     (isQNAN_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .isInvalid_o  (isInvalid_o),
        .isOverflow_o (isOverflow_o),
        .isUnderflow_o(isUnderflow_o),
        .isInexact_o  (isInexact_o),
        .isDivZero_o  (isDivZero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cls = {isZ, isInf, isSNAN, isQNAN}; flg = {invalid, overflow, underflow, inexact, divzero}
    typedef struct {
        string       name;
        logic        inv;
        logic [1:0]  rnd;
        logic        s;
        logic [8:0]  e;
        logic [27:0] f;
        logic [3:0]  cls;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(string name, logic inv, logic [1:0] rnd, logic s, logic [8:0] e,
                                logic [27:0] f, logic [3:0] cls, logic [31:0] res,
                                logic [4:0] flg);
        vec_t v;
        v.name = name; v.inv = inv; v.rnd = rnd; v.s = s; v.e = e; v.f = f;
        v.cls = cls; v.res = res; v.flg = flg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {isInvalid_o, isOverflow_o, isUnderflow_o, isInexact_o, isDivZero_o};
    endfunction

    task automatic drive(input logic v, input logic inv, input logic [1:0] rnd, input logic s,
                         input logic [8:0] e, input logic [27:0] f, input logic [3:0] cls);
        valid_i = v; op_inv_i = inv; rnd_mode_i = rnd; s_i = s; e_i = e; f_i = f;
        {isZ_i, isInf_i, isSNAN_i, isQNAN_i} = cls;
    endtask

    logic [31:0] bp_exp [4];
    logic [31:0] held;
    logic        was_stalled;
    logic        saw_not_ready;
    int          sent;
    int          recv;
    int          stall_ok;

    initial begin
        rst = 1'b1;
        ready_i = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 9'h0, 28'h0, 4'h0);

        vecs.push_back(mk("sqrt1_rne",     0, 2'b00, 0, 9'h000, 28'h8000000, 4'h0, 32'h3F800000, 5'b00000));
        vecs.push_back(mk("rne_carry",     0, 2'b00, 0, 9'h000, 28'hFFFFFF8, 4'h0, 32'h40000000, 5'b00010));
        vecs.push_back(mk("rtz_nocarry",   0, 2'b01, 0, 9'h000, 28'hFFFFFF8, 4'h0, 32'h3FFFFFFF, 5'b00010));
        vecs.push_back(mk("ovf_rne",       0, 2'b00, 0, 9'h080, 28'h8000000, 4'h0, 32'h7F800000, 5'b01010));
        vecs.push_back(mk("ovf_rtz",       0, 2'b01, 0, 9'h080, 28'h8000000, 4'h0, 32'h7F7FFFFF, 5'b01010));
        vecs.push_back(mk("ovf_rup",       0, 2'b10, 0, 9'h080, 28'h8000000, 4'h0, 32'h7F800000, 5'b01010));
        vecs.push_back(mk("ovf_rdn",       0, 2'b11, 0, 9'h080, 28'h8000000, 4'h0, 32'h7F7FFFFF, 5'b01010));
        vecs.push_back(mk("ovf_by_carry",  0, 2'b00, 0, 9'h07F, 28'hFFFFFF8, 4'h0, 32'h7F800000, 5'b01010));
        vecs.push_back(mk("max_exp",       0, 2'b00, 0, 9'h07F, 28'h8000000, 4'h0, 32'h7F000000, 5'b00000));
        vecs.push_back(mk("unf_rne",       0, 2'b00, 0, 9'h181, 28'h8000000, 4'h0, 32'h00000000, 5'b00110));
        vecs.push_back(mk("min_normal",    0, 2'b00, 0, 9'h182, 28'h8000000, 4'h0, 32'h00800000, 5'b00000));
        vecs.push_back(mk("rup_inc",       0, 2'b10, 0, 9'h000, 28'h8000011, 4'h0, 32'h3F800002, 5'b00010));
        vecs.push_back(mk("rne_sticky_lo", 0, 2'b00, 0, 9'h000, 28'h8000011, 4'h0, 32'h3F800001, 5'b00010));
        vecs.push_back(mk("rdn_pos",       0, 2'b11, 0, 9'h000, 28'h8000011, 4'h0, 32'h3F800001, 5'b00010));
        vecs.push_back(mk("rne_tie_even",  0, 2'b00, 0, 9'h000, 28'h8000008, 4'h0, 32'h3F800000, 5'b00010));
        vecs.push_back(mk("rne_tie_odd",   0, 2'b00, 0, 9'h000, 28'h8000018, 4'h0, 32'h3F800002, 5'b00010));
        vecs.push_back(mk("snan",          0, 2'b00, 0, 9'h000, 28'h8000000, 4'h2, 32'h7FC00000, 5'b10000));
        vecs.push_back(mk("qnan",          0, 2'b00, 0, 9'h000, 28'h8000000, 4'h1, 32'h7FC00000, 5'b00000));
        vecs.push_back(mk("neg_finite",    0, 2'b00, 1, 9'h000, 28'h8000000, 4'h0, 32'h7FC00000, 5'b10000));
        vecs.push_back(mk("negzero_sqrt",  0, 2'b00, 1, 9'h000, 28'h0000000, 4'h8, 32'h80000000, 5'b00000));
        vecs.push_back(mk("zero_inv",      1, 2'b00, 0, 9'h000, 28'h0000000, 4'h8, 32'h7F800000, 5'b00001));
        vecs.push_back(mk("pinf_inv",      1, 2'b00, 0, 9'h000, 28'h0000000, 4'h4, 32'h00000000, 5'b00000));
        vecs.push_back(mk("pinf_sqrt",     0, 2'b00, 0, 9'h000, 28'h0000000, 4'h4, 32'h7F800000, 5'b00000));
        vecs.push_back(mk("ninf_sqrt",     0, 2'b00, 1, 9'h000, 28'h0000000, 4'h4, 32'h7FC00000, 5'b10000));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_o", {31'b0, valid_o}, 32'd0);
        chk("reset_ready_o", {31'b0, ready_o}, 32'd1);
        chk("reset_result",  result_o, 32'h0);
        rst = 1'b0;

        // Each vector goes in alone; output expected exactly two edges after it is presented.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b1, vecs[i].inv, vecs[i].rnd, vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].cls);
            @(posedge clk);
            @(negedge clk);
            valid_i = 1'b0;
            chk({vecs[i].name, "_early"}, {31'b0, valid_o}, 32'd0);
            @(negedge clk);
            chk({vecs[i].name, "_valid"}, {31'b0, valid_o}, 32'd1);
            chk({vecs[i].name, "_result"}, result_o, vecs[i].res);
            chk({vecs[i].name, "_flags"}, {27'b0, flags()}, {27'b0, vecs[i].flg});
        end

        // Backpressure: four beats, ready_i low for three cycles mid-stream.
        bp_exp[0] = 32'h3F800000; bp_exp[1] = 32'h40000000;
        bp_exp[2] = 32'h40800000; bp_exp[3] = 32'h41000000;
        sent = 0; recv = 0; stall_ok = 1; was_stalled = 1'b0; saw_not_ready = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            @(negedge clk);
            ready_i = !(cyc >= 3 && cyc < 6);
            if (sent < 4) drive(1'b1, 1'b0, 2'b00, 1'b0, 9'(sent), 28'h8000000, 4'h0);
            else          valid_i = 1'b0;
            #1;
            if (was_stalled) chk("bp_hold", result_o, held);
            was_stalled = valid_o && !ready_i;
            held = result_o;
            if (!ready_o) saw_not_ready = 1'b1;
            if (valid_o && ready_i) begin
                chk("bp_order", result_o, bp_exp[recv]);
                recv++;
            end
            if (valid_i && ready_o) sent++;
        end
        @(negedge clk);
        valid_i = 1'b0;
        chk("bp_count", 32'(recv), 32'd4);
        chk("bp_ready_dropped", {31'b0, saw_not_ready}, 32'd1);

        // Reset with both stages full: nothing may come out afterwards.
        ready_i = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 9'h001, 28'h8000000, 4'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 9'h002, 28'h8000000, 4'h0);
        @(negedge clk);
        valid_i = 1'b0;
        chk("rst_pre_full", {31'b0, ready_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
        chk("rst_ready_o", {31'b0, ready_o}, 32'd1);
        chk("rst_result",  result_o, 32'h0);
        ready_i = 1'b1;
        recv = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (valid_o) recv++;
        end
        chk("rst_no_output", 32'(recv), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
